// File: rtl/port_pkg.sv
// Shared types and helpers for the multi-bank write port: FSM states,
// default widths and the (channel, group, lane) -> bank index mapping.
package port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam int DEF_BANK_W = 128;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_CNT_W  = 13;

    // Banks are laid out channel-major, then ping-pong group, then lane.
    function automatic int bank_idx(input int ch, input int grp, input int lane, input int split);
        return ch * 2 * split + grp * split + lane;
    endfunction

endpackage

// File: rtl/port_arb.sv
// Per-channel start queue: pending latch, lowest-index-first grant and
// sticky collision errors for starts that hit a pending or active channel.
module port_arb #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] start,
    input  logic              grant_en,
    input  logic [NUM_CH-1:0] active,
    output logic              grant,
    output logic [CH_W-1:0]   grant_ch,
    output logic [NUM_CH-1:0] err
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] grant_mask;

    // Scanning downwards leaves the lowest pending index as the winner.
    always_comb begin
        grant      = 1'b0;
        grant_ch   = '0;
        grant_mask = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (grant_en && pend[c]) begin
                grant    = 1'b1;
                grant_ch = CH_W'(c);
            end
        end
        if (grant) begin
            grant_mask[grant_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            err  <= '0;
        end else begin
            pend <= (pend & ~grant_mask) | (start & ~pend & ~active);
            err  <= err | (start & (pend | active));
        end
    end

endmodule

// File: rtl/multi_bank_port.sv
// Multi-channel ping-pong bank loader: one transfer at a time, registered bank
// write port. Optional stall counter is enabled with macro PORT_STALL_CNT_EN.
module multi_bank_port
    import port_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SPLIT  = 2,
    parameter int BANK_W = DEF_BANK_W,
    parameter int DIN_W  = SPLIT * BANK_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int NB     = NUM_CH * 2 * SPLIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    start_i,
    input  logic [CNT_W-1:0]     tran_time_i,
    input  logic [DIN_W-1:0]     data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [NUM_CH-1:0]    done_o,
    output logic [NUM_CH-1:0]    pp_o,
    output logic [NUM_CH-1:0]    err_o,
    output logic [15:0]          stall_cnt_o,
    output logic [NB-1:0]        bce_o,
    output logic [NB*ADDR_W-1:0] bwaddr_o,
    output logic [NB*BANK_W-1:0] bwdata_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   act_ch;
    logic [CH_W-1:0]   grant_ch;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] pp;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] done;
    logic              grant;
    logic              accept;
    logic              last_beat;
    logic              pp_cur;

    assign ready_o   = (state == XFER);
    assign busy_o    = (state == XFER);
    assign accept    = valid_i & ready_o;
    assign last_beat = (beat_cnt + CNT_W'(1)) == len;
    assign pp_cur    = pp[act_ch];
    assign pp_o      = pp;
    assign done_o    = done;

    // The owning channel stays "active" through DONE so late starts flag an error.
    always_comb begin
        active = '0;
        if (state != IDLE) begin
            active[act_ch] = 1'b1;
        end
    end

    port_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .start    (start_i),
        .grant_en (state == IDLE),
        .active   (active),
        .grant    (grant),
        .grant_ch (grant_ch),
        .err      (err_o)
    );

    always_comb begin
        state_nxt = state;
        done      = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = (tran_time_i == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (accept && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done[act_ch] = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            act_ch   <= '0;
            len      <= '0;
            beat_cnt <= '0;
            addr     <= '0;
            pp       <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                act_ch   <= grant_ch;
                len      <= tran_time_i;
                beat_cnt <= '0;
                addr     <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                addr     <= addr + ADDR_W'(1);
            end
            if (state == DONE) begin
                pp[act_ch] <= ~pp[act_ch];
            end
        end
    end

    // One register slice per bank; unstrobed banks keep their last address/data.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        for (genvar g = 0; g < 2; g++) begin : g_grp
            for (genvar l = 0; l < SPLIT; l++) begin : g_lane
                localparam int B = bank_idx(ch, g, l, SPLIT);
                logic              bce_r;
                logic [ADDR_W-1:0] addr_r;
                logic [BANK_W-1:0] data_r;
                logic              hit;

                assign hit = accept && (act_ch == CH_W'(ch)) && (pp_cur == 1'(g));

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        bce_r  <= 1'b0;
                        addr_r <= '0;
                        data_r <= '0;
                    end else begin
                        bce_r <= hit;
                        if (hit) begin
                            addr_r <= addr;
                            data_r <= data_i[l*BANK_W +: BANK_W];
                        end
                    end
                end

                assign bce_o[B]                     = bce_r;
                assign bwaddr_o[B*ADDR_W +: ADDR_W] = addr_r;
                assign bwdata_o[B*BANK_W +: BANK_W] = data_r;
            end
        end
    end

`ifdef PORT_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (grant) begin
            stall_cnt <= '0;
        end else if (state == XFER && !valid_i && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multi_bank_port.sv
// Self-checking bench for multi_bank_port (3-bit address build to exercise wrap);
// a cycle model of the transfer rules is compared against the DUT every cycle.
module tb_multi_bank_port;

    localparam int NUM_CH = 2;
    localparam int SPLIT  = 2;
    localparam int BANK_W = 128;
    localparam int DIN_W  = SPLIT * BANK_W;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 13;
    localparam int NB     = NUM_CH * 2 * SPLIT;
`ifdef PORT_STALL_CNT_EN
    localparam int STALL_EXP = 3;
`else
    localparam int STALL_EXP = 0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    start_i;
    logic [CNT_W-1:0]     tran_time_i;
    logic [DIN_W-1:0]     data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 busy_o;
    logic [NUM_CH-1:0]    done_o;
    logic [NUM_CH-1:0]    pp_o;
    logic [NUM_CH-1:0]    err_o;
    logic [15:0]          stall_cnt_o;
    logic [NB-1:0]        bce_o;
    logic [NB*ADDR_W-1:0] bwaddr_o;
    logic [NB*BANK_W-1:0] bwdata_o;

    int tests_run = 0;
    int tests_failed = 0;

    multi_bank_port #(
        .NUM_CH (NUM_CH),
        .SPLIT  (SPLIT),
        .BANK_W (BANK_W),
        .DIN_W  (DIN_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .NB     (NB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .tran_time_i (tran_time_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pp_o        (pp_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o),
        .bce_o       (bce_o),
        .bwaddr_o    (bwaddr_o),
        .bwdata_o    (bwdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat data: lane l carries {beat tag, l}; the tag advances on every accepted beat.
    logic [7:0] beat_seq;
    always @(posedge clk or posedge rst) begin
        if (rst) beat_seq <= 8'hA0;
        else if (valid_i && ready_o) beat_seq <= beat_seq + 8'd1;
    end

    always_comb begin
        data_i = '0;
        for (int l = 0; l < SPLIT; l++) data_i[l*BANK_W +: BANK_W] = BANK_W'({beat_seq, 4'(l)});
    end

    // Reference model: a channel owns the port from grant until its done cycle;
    // m_left counts beats still owed, and zero beats left means the done cycle.
    bit [NUM_CH-1:0]   m_pend, m_err, m_pp;
    int                m_cur, m_left, m_addr, m_stall;
    bit [NB-1:0]       m_bce;
    logic [ADDR_W-1:0] m_waddr [NB];
    logic [BANK_W-1:0] m_wdata [NB];

    always @(posedge clk or posedge rst) begin : model
        if (rst) begin
            m_pend <= '0; m_err <= '0; m_pp <= '0;
            m_cur <= -1; m_left <= 0; m_addr <= 0; m_stall <= 0; m_bce <= '0;
            for (int b = 0; b < NB; b++) begin
                m_waddr[b] <= '0;
                m_wdata[b] <= '0;
            end
        end else begin
            automatic bit [NUM_CH-1:0] pend_n = m_pend;
            automatic bit [NUM_CH-1:0] err_n = m_err;
            automatic bit [NUM_CH-1:0] pp_n = m_pp;
            automatic int cur_n = m_cur, left_n = m_left, addr_n = m_addr, stall_n = m_stall;
            automatic bit [NB-1:0] bce_n = '0;
            automatic int b = 0;
            automatic int g = -1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (start_i[c]) begin
                    if (m_pend[c] || m_cur == c) err_n[c] = 1'b1;
                    else pend_n[c] = 1'b1;
                end
            end
            if (m_cur >= 0 && m_left > 0) begin
                if (valid_i) begin
                    for (int l = 0; l < SPLIT; l++) begin
                        b = m_cur * 2 * SPLIT + int'(m_pp[m_cur]) * SPLIT + l;
                        bce_n[b] = 1'b1;
                        m_waddr[b] <= ADDR_W'(m_addr);
                        m_wdata[b] <= data_i[l*BANK_W +: BANK_W];
                    end
                    addr_n = (m_addr + 1) % (1 << ADDR_W);
                    left_n = m_left - 1;
                end else if (m_stall < 65535) begin
                    stall_n = m_stall + 1;
                end
            end else if (m_cur >= 0) begin
                pp_n[m_cur] = ~m_pp[m_cur];
                cur_n = -1;
            end else begin
                for (int c = NUM_CH - 1; c >= 0; c--) if (m_pend[c]) g = c;
                if (g >= 0) begin
                    pend_n[g] = 1'b0;
                    cur_n = g;
                    left_n = int'(tran_time_i);
                    addr_n = 0;
                    stall_n = 0;
                end
            end
            m_pend <= pend_n; m_err <= err_n; m_pp <= pp_n; m_cur <= cur_n;
            m_left <= left_n; m_addr <= addr_n; m_stall <= stall_n; m_bce <= bce_n;
        end
    end

    task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        if (!rst) begin
            automatic bit [NUM_CH-1:0] e_done = '0;
            automatic logic [NB*ADDR_W-1:0] e_wa = '0;
            automatic logic [NB*BANK_W-1:0] e_wd = '0;
            automatic bit e_xfer = (m_cur >= 0) && (m_left > 0);
            automatic logic [15:0] e_stall = '0;
            if (m_cur >= 0 && m_left == 0) e_done[m_cur] = 1'b1;
            for (int b = 0; b < NB; b++) begin
                e_wa[b*ADDR_W +: ADDR_W] = m_waddr[b];
                e_wd[b*BANK_W +: BANK_W] = m_wdata[b];
            end
`ifdef PORT_STALL_CNT_EN
            e_stall = 16'(m_stall);
`endif
            checkOutput("ready", ready_o, e_xfer);
            checkOutput("busy", busy_o, e_xfer);
            checkOutput("done", done_o, e_done);
            checkOutput("pp", pp_o, m_pp);
            checkOutput("err", err_o, m_err);
            checkOutput("bce", bce_o, m_bce);
            checkOutput("bwaddr", bwaddr_o, e_wa);
            checkOutput("bwdata", bwdata_o, e_wd);
            checkOutput("stall", stall_cnt_o, e_stall);
        end
    end

    // Independent tallies of strobes and done pulses for the literal checks.
    int strobes [NB];
    int done_cnt [NUM_CH];
    int done_cyc [NUM_CH];
    int cyc = 0;
    always @(negedge clk) begin
        if (!rst) begin
            cyc <= cyc + 1;
            for (int b = 0; b < NB; b++) if (bce_o[b]) strobes[b] <= strobes[b] + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (done_o[c]) begin
                    done_cnt[c] <= done_cnt[c] + 1;
                    done_cyc[c] <= cyc;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [NUM_CH-1:0] st, input int len, input logic v);
        @(posedge clk);
        #2;
        start_i     = st;
        tran_time_i = CNT_W'(len);
        valid_i     = v;
    endtask

    task automatic waitDone(input int ch, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o[ch] === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL done_timeout ch%0d: got no done pulse, required one within %0d cycles", ch, budget);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit reached;
        logic [7:0] base;
        rst = 1'b1; start_i = '0; tran_time_i = '0; valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_bce", bce_o, '0);
        checkOutput("reset_busy", busy_o, 1'b0);
        checkOutput("reset_wdata", bwdata_o, '0);
        rst = 1'b0;

        // ch0, four beats into group 0
        applyStimulus(2'b01, 4, 1'b1);
        applyStimulus(2'b00, 4, 1'b1);
        waitDone(0, 20);
        checkOutput("t1_last_strobe", bce_o, 8'h03);
        applyStimulus(2'b00, 4, 1'b1);
        checkOutput("t1_pp", pp_o, 2'b01);
        checkOutput("t1_addr_b0", bwaddr_o[0 +: ADDR_W], 3'd3);
        checkOutput("t1_data_b1", bwdata_o[BANK_W +: BANK_W], 128'hA31);
        checkOutput("t1_strobes_b0", strobes[0], 4);

        // ch0 again, two beats into group 1
        applyStimulus(2'b01, 2, 1'b1);
        applyStimulus(2'b00, 2, 1'b1);
        waitDone(0, 20);
        checkOutput("t2_last_strobe", bce_o, 8'h0C);
        applyStimulus(2'b00, 2, 1'b1);
        checkOutput("t2_pp", pp_o, 2'b00);
        checkOutput("t2_addr_b2", bwaddr_o[2*ADDR_W +: ADDR_W], 3'd1);
        checkOutput("t2_data_b3", bwdata_o[3*BANK_W +: BANK_W], 128'hA51);

        // both channels at once: ch0 first, ch1 five cycles after ch0's done
        applyStimulus(2'b11, 3, 1'b1);
        applyStimulus(2'b00, 3, 1'b1);
        waitDone(1, 40);
        applyStimulus(2'b00, 3, 1'b1);
        checkOutput("t3_done_gap", done_cyc[1] - done_cyc[0], 5);
        checkOutput("t3_err", err_o, 2'b00);
        checkOutput("t3_strobes_b4", strobes[4], 3);
        checkOutput("t3_pp", pp_o, 2'b11);

        // double start on ch1 before its grant
        applyStimulus(2'b10, 2, 1'b1);
        applyStimulus(2'b10, 2, 1'b1);
        applyStimulus(2'b00, 2, 1'b1);
        waitDone(1, 20);
        repeat (8) applyStimulus(2'b00, 2, 1'b1);
        checkOutput("t4_err", err_o, 2'b10);
        checkOutput("t4_done_cnt", done_cnt[1], 2);
        checkOutput("t4_strobes_b6", strobes[6], 2);
        checkOutput("t4_pp", pp_o, 2'b01);

        // ten beats through an 8-entry address space
        applyStimulus(2'b01, 10, 1'b1);
        applyStimulus(2'b00, 10, 1'b1);
        waitDone(0, 40);
        applyStimulus(2'b00, 10, 1'b1);
        checkOutput("t5_addr_b2", bwaddr_o[2*ADDR_W +: ADDR_W], 3'd1);
        checkOutput("t5_strobes_b2", strobes[2], 12);
        checkOutput("t5_err", err_o, 2'b10);

        // five beats with a three-cycle valid gap after the second beat
        base = beat_seq;
        applyStimulus(2'b01, 5, 1'b1);
        applyStimulus(2'b00, 5, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (beat_seq == base + 8'd2) reached = 1'b1;
            else begin @(posedge clk); #2; end
        end
        checkOutput("t6_two_beats", reached, 1'b1);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        valid_i = 1'b1;
        waitDone(0, 30);
        applyStimulus(2'b00, 5, 1'b1);
        checkOutput("t6_stall", stall_cnt_o, 16'(STALL_EXP));
        checkOutput("t6_strobes_b0", strobes[0], 12);

        // reset in the middle of a ch1 transfer
        applyStimulus(2'b10, 6, 1'b1);
        applyStimulus(2'b00, 6, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t7_bce", bce_o, '0);
        checkOutput("t7_busy", busy_o, 1'b0);
        checkOutput("t7_ready", ready_o, 1'b0);
        checkOutput("t7_err", err_o, '0);
        checkOutput("t7_pp", pp_o, '0);
        checkOutput("t7_waddr", bwaddr_o, '0);
        checkOutput("t7_wdata", bwdata_o, '0);
        checkOutput("t7_done", done_o, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) applyStimulus(2'b00, 6, 1'b1);
        checkOutput("t7_no_done", done_cnt[1], 2);
        checkOutput("t7_idle", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
